// File: rtl/decoder_38_seq.sv
// decoder_38_seq: queued 3-to-8 one-hot decoder that holds each word HOLD_CYCLES then idles GAP_CYCLES
// Ports: clk, rst (sync active-high); code_in/code_valid/code_ready handshake into a 2-entry queue;
//        flush clears queue and sequencer; data_out one-hot or zero, data_valid, busy, fifo_count (0..2).
module decoder_38_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       flush,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic [1:0] fifo_count
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    state_t     state, state_nxt;
    logic [2:0] mem [2];
    logic       wr_ptr, rd_ptr, push, pop, have;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] data_nxt;
    logic [2:0] head;
    assign head       = mem[rd_ptr];
    assign have       = fifo_count != 2'd0;
    assign code_ready = !rst && !flush && fifo_count != 2'd2;
    assign push       = code_valid && code_ready;
    assign data_valid = |data_out;
    assign busy       = state != IDLE || have;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_out;
        pop       = 1'b0;
        case (state)
            IDLE: if (have) begin
                pop       = 1'b1;
                data_nxt  = 8'd1 << head;
                cnt_nxt   = 4'(HOLD_CYCLES - 1);
                state_nxt = HOLD;
            end
            HOLD: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else if (GAP_CYCLES > 0) begin
                data_nxt  = 8'd0;
                cnt_nxt   = 4'(GAP_CYCLES - 1);
                state_nxt = GAP;
            end else if (have) begin
                pop      = 1'b1;
                data_nxt = 8'd1 << head;
                cnt_nxt  = 4'(HOLD_CYCLES - 1);
            end else begin
                data_nxt  = 8'd0;
                state_nxt = IDLE;
            end
            GAP: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else if (have) begin
                pop       = 1'b1;
                data_nxt  = 8'd1 << head;
                cnt_nxt   = 4'(HOLD_CYCLES - 1);
                state_nxt = HOLD;
            end else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= code_in;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            data_out   <= 8'd0;
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_out   <= data_nxt;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
            wr_ptr     <= wr_ptr ^ push;
            rd_ptr     <= rd_ptr ^ pop;
        end
    end
endmodule

// File: tb/tb_decoder_38_seq.sv
// tb_decoder_38_seq: schedule-based reference model checks two parameterisations under directed and random stimulus
module tb_decoder_38_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    typedef struct {int code; int st;} rec_t;
    task automatic check(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int H = g ? 1 : 4;
        localparam int G = g ? 0 : 1;
        logic       rst, flush, code_valid, code_ready, data_valid, busy;
        logic [2:0] code_in;
        logic [7:0] data_out;
        logic [1:0] fifo_count;
        bit         fin = 1'b0, took;
        rec_t       recs[$];
        int         t = 0, last_st = -1000;
        decoder_38_seq #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
            .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
            .code_ready(code_ready), .flush(flush), .data_out(data_out),
            .data_valid(data_valid), .busy(busy), .fifo_count(fifo_count)
        );
        function automatic int m_count();
            int n = 0;
            foreach (recs[i]) if (recs[i].st > t) n++;
            return n;
        endfunction
        function automatic int m_data();
            foreach (recs[i]) if (recs[i].st <= t && t < recs[i].st + H) return 1 << recs[i].code;
            return 0;
        endfunction
        function automatic int m_busy();
            foreach (recs[i]) if (t < recs[i].st + H + G) return 1;
            return 0;
        endfunction
        task automatic cycle(bit r, bit f, bit v, int c);
            int s, d;
            bit acc;
            @(negedge clk);
            rst = r;
            flush = f;
            code_valid = v;
            code_in = 3'(c);
            #1;
            acc = !r && !f && m_count() != 2;
            check($sformatf("cfg%0d ready t%0d", g, t), int'(code_ready), int'(acc));
            took = acc && v;
            @(posedge clk);
            t++;
            if (r || f) begin
                recs.delete();
                last_st = -1000;
            end else if (took) begin
                s = (t + 1 > last_st + H + G) ? t + 1 : last_st + H + G;
                recs.push_back('{c, s});
                last_st = s;
            end
            while (recs.size() > 0 && recs[0].st + H + G <= t) void'(recs.pop_front());
            #1;
            d = m_data();
            check($sformatf("cfg%0d data t%0d", g, t), int'(data_out), d);
            check($sformatf("cfg%0d valid t%0d", g, t), int'(data_valid), int'(d != 0));
            check($sformatf("cfg%0d busy t%0d", g, t), int'(busy), m_busy());
            check($sformatf("cfg%0d count t%0d", g, t), int'(fifo_count), m_count());
        endtask
        initial begin
            repeat (2) cycle(1, 0, 1, 6);
            cycle(0, 0, 0, 0);
            cycle(0, 0, 1, 5);
            repeat (8) cycle(0, 0, 0, 0);
            for (int c = 0; c < 8; c++) begin
                do cycle(0, 0, 1, c); while (!took);
            end
            repeat (50) cycle(0, 0, 0, 0);
            cycle(0, 0, 1, 3);
            cycle(0, 0, 1, 1);
            cycle(0, 0, 1, 4);
            cycle(0, 1, 1, 7);
            repeat (12) cycle(0, 0, 0, 0);
            cycle(0, 0, 1, 2);
            cycle(0, 0, 1, 6);
            cycle(0, 0, 0, 0);
            cycle(1, 0, 0, 0);
            repeat (10) cycle(0, 0, 0, 0);
            cycle(0, 0, 1, 0);
            cycle(0, 0, 1, 7);
            repeat (10) cycle(0, 0, 0, 0);
            for (int i = 0; i < 1500; i++)
                cycle($urandom_range(99) == 0, $urandom_range(39) == 0,
                      $urandom_range(9) < 6, int'($urandom_range(7)));
            fin = 1'b1;
        end
    end
    initial begin
        fork
            wait (cfg[0].fin && cfg[1].fin);
            begin
                #500000;
                n_bad++;
                $display("FAIL timeout: got unfinished expected finished");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decoder_38_seq.md
DECODER_38_SEQ -- requirements
Module: decoder_38_seq

Interface
REQ-001 Parameter HOLD_CYCLES SHALL be: HOLD_CYCLES, 4, cycles each one-hot word is driven (legal 1..15).
REQ-002 Parameter GAP_CYCLES SHALL be: GAP_CYCLES, 1, all-zero cycles inserted after each hold (legal 0..15).
REQ-003 Port clk SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst SHALL be: rst  input  1  synchronous active-high reset.
REQ-005 Port code_in SHALL be: code_in  input  3  binary code to decode.
REQ-006 Port code_valid SHALL be: code_valid  input  1  code_in valid this cycle.
REQ-007 Port code_ready SHALL be: code_ready  output  1  block accepts code_in this cycle.
REQ-008 Port flush SHALL be: flush  input  1  synchronous clear of queue and sequencer.
REQ-009 Port data_out SHALL be: data_out  output  8  registered one-hot decode (1 << code), or all zero.
REQ-010 Port data_valid SHALL be: data_valid  output  1  high exactly when data_out is non-zero.
REQ-011 Port busy SHALL be: busy  output  1  FSM not IDLE or queue non-empty.
REQ-012 Port fifo_count SHALL be: fifo_count  output  2  queued codes (0..2).

Function
REQ-013 Handshake: code accepted on a rising edge where code_valid=1 and code_ready=1; no other edge SHALL accept.
REQ-014 Queue: 2-entry FIFO, order preserved; code_ready = (fifo_count != 2), combinational from registered count.
REQ-015 Push and pop on the same edge SHALL leave fifo_count unchanged; pop SHALL occur only when non-empty.
REQ-016 FSM states SHALL be IDLE, HOLD, GAP; data_out SHALL be non-zero only in HOLD.
REQ-017 IDLE: if queue non-empty, pop head, load data_out = 1 << head, load hold counter = HOLD_CYCLES-1, go HOLD; else stay, data_out = 0.
REQ-018 HOLD: counter decrements each edge while non-zero; at counter 0 on an edge: if GAP_CYCLES>0, data_out=0, load gap counter = GAP_CYCLES-1, go GAP; if GAP_CYCLES=0 and queue non-empty, pop and reload (stay HOLD); else data_out=0, go IDLE.
REQ-019 GAP: counter decrements each edge while non-zero; at counter 0 on an edge: if queue non-empty, pop, load data_out, go HOLD; else go IDLE.
REQ-020 Latency: code accepted at edge N into empty queue with FSM IDLE SHALL drive data_out from edge N+1 for exactly HOLD_CYCLES cycles.
REQ-021 Steady-state period with queue never empty SHALL be HOLD_CYCLES+GAP_CYCLES cycles per code.
REQ-022 Push attempted while full SHALL be ignored and queue contents unchanged.
REQ-023 flush=1 on an edge SHALL empty queue, force IDLE, data_out=0, counters 0; a code offered the same edge SHALL NOT be accepted (code_ready forced 0 while flush=1).
REQ-024 Every code 0..7 SHALL decode to exactly one set bit; no X ever driven on data_out.

Reset
REQ-025 rst=1 on an edge SHALL set data_out=8'h00, data_valid=0, fifo_count=0, busy=0, FSM IDLE, counters 0.
REQ-026 rst SHALL take priority over flush and handshake; code_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-027 rst asserted mid-HOLD SHALL zero data_out on that edge and discard all queued codes.

Verification (default HOLD_CYCLES=4, GAP_CYCLES=1 unless stated)
REQ-028 rst high 2 cycles with code_valid=1, code_in=3'd6 -> no accept, data_out=8'h00, code_ready=1 after release.
REQ-029 Single code 3'd5 accepted at edge N -> data_out=8'h20 after edges N+1..N+4, 8'h00 after N+5, busy=0 after N+6.
REQ-030 Codes 0..7 offered back-to-back with code_valid held -> code_ready drops at fifo_count=2; data_out sequence 01,02,04,...,80, each 4 cycles, 1 zero cycle between, none lost.
REQ-031 flush asserted on 2nd HOLD cycle of 3'd3 with 2 codes queued -> data_out=8'h00, fifo_count=0, busy=0 after that edge; queued codes never appear.
REQ-032 HOLD_CYCLES=1, GAP_CYCLES=0: codes 3'd0 then 3'd7 on consecutive edges -> data_out 8'h01 then 8'h80 on consecutive cycles, no zero cycle between.
REQ-033 rst pulsed during HOLD of 3'd2 with 1 code queued -> data_out=8'h00, fifo_count=0 after reset edge; no output until new code accepted.
